// File: rtl/ps2_kbd_tx_pkg.sv
// Shared PS/2 definitions: FSM state encoding, frame geometry and the
// odd-parity / frame-bit helpers also used by the host-side receiver.
package ps2_kbd_tx_pkg;

    typedef enum logic [1:0] {
        PS2_IDLE = 2'd0,
        PS2_GAP  = 2'd1,
        PS2_HIGH = 2'd2,
        PS2_LOW  = 2'd3
    } ps2_state_e;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [3:0] PS2_STOP_IDX   = 4'(PS2_FRAME_BITS - 1);

    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Frame layout: start 0, data LSB first, odd parity, stop 1.
    function automatic logic ps2_frame_bit(input logic [7:0] d, input logic [3:0] idx);
        if (idx == 4'd0)
            return 1'b0;
        else if (idx <= 4'd8)
            return d[3'(idx - 4'd1)];
        else if (idx == 4'd9)
            return ps2_odd_parity(d);
        else
            return 1'b1;
    endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Byte valid/ready handshake into the PS/2 keyboard transmitter.
interface ps2_kbd_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_kbd_tx_fifo.sv
// Small synchronous FIFO (count-based full/empty, show-ahead head) placed in
// front of the PS/2 serialiser. DEPTH must be a power of two, at least 2.
module ps2_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A push while full still lands if the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)
            count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push)
            count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter with host-inhibit abort/retry.
// Define PS2_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front of the serialiser.
module ps2_kbd_tx
    import ps2_kbd_tx_pkg::*;
#(
    parameter int CLK_DIV    = 2000,
    parameter int IDLE_GAP   = 2500,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    ps2_kbd_tx_if.slave  tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    output logic         busy,
    output logic         aborted
);
    localparam int CNT_MAX = (CLK_DIV > IDLE_GAP) ? CLK_DIV : IDLE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(IDLE_GAP - 1);
    // Our own clock release needs two cycles to reach the synchroniser output.
    localparam logic [CNT_W-1:0] INH_FIRST = CNT_W'(2);

    logic [1:0] pad_raw;
    logic [1:0] line_sync;
    logic       line_clk, line_data;

    assign pad_raw = {ps2_data_in, ps2_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_q, s2_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_q <= 1'b1;
                    s2_q <= 1'b1;
                end else begin
                    s1_q <= pad_raw[gi];
                    s2_q <= s1_q;
                end
            end
            assign line_sync[gi] = s2_q;
        end
    endgenerate

    assign line_clk  = line_sync[0];
    assign line_data = line_sync[1];

    logic       push, pop, pending;
    logic [7:0] head_data;

    assign push = tx.tx_valid && tx.tx_ready;

`ifdef PS2_TX_FIFO_EN
    logic fifo_full, fifo_empty;

    ps2_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .data_i  (tx.tx_data),
        .pop_i   (pop),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pending     = !fifo_empty;
    assign tx.tx_ready = !fifo_full;
`else
    logic       hold_valid_q;
    logic [7:0] hold_data_q;
    logic       unused_cfg;

    assign unused_cfg = (FIFO_DEPTH > 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= 8'h00;
        end else begin
            if (pop) hold_valid_q <= 1'b0;
            if (push) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= tx.tx_data;
            end
        end
    end

    assign pending     = hold_valid_q;
    assign head_data   = hold_data_q;
    assign tx.tx_ready = !hold_valid_q;
`endif

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic             aborted_q, abort_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        abort_w = 1'b0;
        case (state_q)
            PS2_IDLE: begin
                cnt_d = '0;
                if (pending) state_d = PS2_GAP;
            end
            PS2_GAP: begin
                // Any low on either line (inhibit or request-to-send) restarts the gap.
                if (line_clk && line_data) begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = PS2_HIGH;
                        cnt_d   = '0;
                        bit_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            PS2_HIGH: begin
                if (!line_clk && cnt_q >= INH_FIRST && bit_q != PS2_STOP_IDX) begin
                    abort_w = 1'b1;
                    state_d = PS2_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DIV_LAST) begin
                    state_d = PS2_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PS2_LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (bit_q == PS2_STOP_IDX) begin
                        state_d = PS2_IDLE;
                        pop     = 1'b1;
                    end else begin
                        state_d = PS2_HIGH;
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = PS2_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= PS2_IDLE;
            cnt_q     <= '0;
            bit_q     <= 4'd0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            aborted_q <= abort_w;
        end
    end

    assign ps2_clk_oe  = (state_q == PS2_LOW);
    assign ps2_data_oe = ((state_q == PS2_HIGH) || (state_q == PS2_LOW)) &&
                         !ps2_frame_bit(head_data, bit_q);
    assign busy        = (state_q != PS2_IDLE);
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: a host model samples data on every PS/2 clock falling
// edge and frames are compared against bytes expanded from the PS/2 frame rules.
module tb_ps2_kbd_tx;
    localparam int CLK_DIV    = 4;
    localparam int IDLE_GAP   = 8;
    localparam int FIFO_DEPTH = 4;
`ifdef PS2_TX_FIFO_EN
    localparam int QDEPTH = FIFO_DEPTH;
`else
    localparam int QDEPTH = 1;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic host_clk_pull = 1'b0;
    logic ps2_clk_oe, ps2_data_oe, busy, aborted;
    logic ps2_clk_pad, ps2_data_pad;

    assign ps2_clk_pad  = !(ps2_clk_oe || host_clk_pull);
    assign ps2_data_pad = !ps2_data_oe;

    ps2_kbd_tx_if tx_if ();

    ps2_kbd_tx #(
        .CLK_DIV    (CLK_DIV),
        .IDLE_GAP   (IDLE_GAP),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tx          (tx_if),
        .ps2_clk_in  (ps2_clk_pad),
        .ps2_data_in (ps2_data_pad),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   abort_cycles = 0;
    logic cap_q[$];
    int   fall_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (aborted) abort_cycles <= abort_cycles + 1;

    // Host model: data sampled on falling edges the device generated itself.
    always @(negedge ps2_clk_pad) begin
        if (reset_n && !host_clk_pull) begin
            cap_q.push_back(ps2_data_pad);
            fall_q.push_back(cyc);
        end
    end

    function automatic logic exp_bit(input logic [7:0] d, input int i);
        if (i == 0)  return 1'b0;
        if (i <= 8)  return d[i-1];
        if (i == 9)  return (($countones(d) % 2) == 0);
        return 1'b1;
    endfunction

    task automatic send(input logic [7:0] d);
        int k = 0;
        @(negedge clk);
        while (!tx_if.tx_ready && k < 5000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!tx_if.tx_ready) begin
            $display("FAIL send_timeout: tx_ready=%b required 1 for byte %02h", tx_if.tx_ready, d);
            n_fail++;
        end else begin
            tx_if.tx_data  = d;
            tx_if.tx_valid = 1'b1;
            @(posedge clk);
            #1 tx_if.tx_valid = 1'b0;
        end
    endtask

    task automatic wait_caps(input int n, input string what);
        int k = 0;
        while (cap_q.size() < n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (cap_q.size() < n) begin
            $display("FAIL %s_timeout: captured %0d bits, required %0d", what, cap_q.size(), n);
            n_fail++;
        end
    endtask

    task automatic wait_idle(input string what);
        int k = 0;
        while (busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            $display("FAIL %s_idle: busy=%b required 0", what, busy);
            n_fail++;
        end
    endtask

    task automatic wait_pad_high(input string what);
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!ps2_clk_pad && k < 200);
        n_checks++;
        if (!ps2_clk_pad) begin
            $display("FAIL %s_high_timeout: ps2 clk=%b required 1", what, ps2_clk_pad);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (ps2_clk_oe !== 1'b0)     begin $display("FAIL reset_clk_oe: got %b required 0", ps2_clk_oe); n_fail++; end
        if (ps2_data_oe !== 1'b0)    begin $display("FAIL reset_data_oe: got %b required 0", ps2_data_oe); n_fail++; end
        if (busy !== 1'b0)           begin $display("FAIL reset_busy: got %b required 0", busy); n_fail++; end
        if (aborted !== 1'b0)        begin $display("FAIL reset_aborted: got %b required 0", aborted); n_fail++; end
        if (tx_if.tx_ready !== 1'b1) begin $display("FAIL reset_tx_ready: got %b required 1", tx_if.tx_ready); n_fail++; end
        reset_n = 1'b1;
        $display("reset checked");
    endtask

    task automatic test_single();
        int base = cap_q.size();
        int a0 = abort_cycles;
        logic [10:0] pat;
        pat = 11'b10000111000;
        send(8'h1C);
        wait_caps(base + 11, "single");
        n_checks++;
        if (busy !== 1'b1) begin $display("FAIL single_busy_in_stop: got %b required 1", busy); n_fail++; end
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (cap_q[base+i] !== pat[i]) begin
                $display("FAIL single_bit%0d: got %b required %b", i, cap_q[base+i], pat[i]);
                n_fail++;
            end
        end
        wait_idle("single");
        n_checks += 2;
        if (tx_if.tx_ready !== 1'b1) begin $display("FAIL single_ready: got %b required 1", tx_if.tx_ready); n_fail++; end
        if (abort_cycles != a0)      begin $display("FAIL single_no_abort: got %0d required %0d", abort_cycles, a0); n_fail++; end
        $display("frame byte=1C sent");
    endtask

    task automatic test_back_to_back();
        int base = cap_q.size();
        logic [7:0] b [2];
        b[0] = 8'h00;
        b[1] = 8'hFF;
        send(b[0]);
        send(b[1]);
        wait_caps(base + 22, "b2b");
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if (cap_q[base+11*j+i] !== exp_bit(b[j], i)) begin
                    $display("FAIL b2b_byte%0d_bit%0d: got %b required %b", j, i, cap_q[base+11*j+i], exp_bit(b[j], i));
                    n_fail++;
                end
            end
            $display("frame byte=%02h sent", b[j]);
        end
        n_checks++;
        if (fall_q.size() >= base + 12 && fall_q[base+11] - fall_q[base+10] < 2*CLK_DIV + IDLE_GAP) begin
            $display("FAIL b2b_gap: edge spacing %0d cycles, required at least %0d",
                     fall_q[base+11] - fall_q[base+10], 2*CLK_DIV + IDLE_GAP);
            n_fail++;
        end
        wait_idle("b2b");
    endtask

    task automatic test_inhibit();
        int base = cap_q.size();
        int a0 = abort_cycles;
        int base2;
        send(8'hF0);
        wait_caps(base + 4, "inhibit_pre");
        wait_pad_high("inhibit");
        host_clk_pull = 1'b1;
        repeat (10) @(negedge clk);
        n_checks += 3;
        if (abort_cycles != a0 + 1) begin $display("FAIL inhibit_abort_pulse: got %0d cycles required 1", abort_cycles - a0); n_fail++; end
        if (ps2_clk_oe !== 1'b0)    begin $display("FAIL inhibit_clk_oe: got %b required 0", ps2_clk_oe); n_fail++; end
        if (ps2_data_oe !== 1'b0)   begin $display("FAIL inhibit_data_oe: got %b required 0", ps2_data_oe); n_fail++; end
        repeat (10) @(negedge clk);
        host_clk_pull = 1'b0;
        base2 = cap_q.size();
        n_checks++;
        if (base2 != base + 4) begin $display("FAIL inhibit_bits_before_abort: got %0d required 4", base2 - base); n_fail++; end
        wait_caps(base2 + 11, "inhibit_retry");
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (cap_q[base2+i] !== exp_bit(8'hF0, i)) begin
                $display("FAIL inhibit_retry_bit%0d: got %b required %b", i, cap_q[base2+i], exp_bit(8'hF0, i));
                n_fail++;
            end
        end
        wait_idle("inhibit");
        n_checks++;
        if (abort_cycles != a0 + 1) begin $display("FAIL inhibit_single_abort: got %0d required 1", abort_cycles - a0); n_fail++; end
        $display("frame byte=F0 aborted at bit 4 and resent");
    endtask

    task automatic test_stop_inhibit();
        int base = cap_q.size();
        int a0 = abort_cycles;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        send(d);
        wait_caps(base + 10, "stop_pre");
        wait_pad_high("stop");
        host_clk_pull = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ps2_data_oe !== 1'b0) begin $display("FAIL stop_data_released: got %b required 0", ps2_data_oe); n_fail++; end
        repeat (4) @(negedge clk);
        host_clk_pull = 1'b0;
        wait_idle("stop");
        n_checks += 2;
        if (abort_cycles != a0)      begin $display("FAIL stop_no_abort: got %0d required %0d", abort_cycles, a0); n_fail++; end
        if (tx_if.tx_ready !== 1'b1) begin $display("FAIL stop_popped: tx_ready=%b required 1", tx_if.tx_ready); n_fail++; end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (cap_q[base+i] !== exp_bit(d, i)) begin
                $display("FAIL stop_bit%0d: got %b required %b", i, cap_q[base+i], exp_bit(d, i));
                n_fail++;
            end
        end
        repeat (60) @(negedge clk);
        n_checks += 2;
        if (cap_q.size() != base + 10) begin $display("FAIL stop_no_resend: got %0d bits required 10", cap_q.size() - base); n_fail++; end
        if (busy !== 1'b0)             begin $display("FAIL stop_busy_after: got %b required 0", busy); n_fail++; end
        $display("frame byte=%02h completed through stop-bit inhibit", d);
    endtask

    task automatic test_queueing();
        int base = cap_q.size();
        logic [7:0] b [5];
        b[0] = 8'h12; b[1] = 8'h34; b[2] = 8'h56; b[3] = 8'h78; b[4] = 8'h9A;
        for (int j = 0; j < QDEPTH; j++) send(b[j]);
        @(negedge clk);
        n_checks++;
        if (tx_if.tx_ready !== 1'b0) begin $display("FAIL queue_full_ready: got %b required 0", tx_if.tx_ready); n_fail++; end
        send(b[QDEPTH]);
        n_checks++;
        if (cap_q.size() < base + 11) begin
            $display("FAIL queue_accept_early: %0d bits sent at accept, required at least 11", cap_q.size() - base);
            n_fail++;
        end
        wait_caps(base + 11*(QDEPTH+1), "queue");
        for (int j = 0; j <= QDEPTH; j++) begin
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if (cap_q[base+11*j+i] !== exp_bit(b[j], i)) begin
                    $display("FAIL queue_byte%0d_bit%0d: got %b required %b", j, i, cap_q[base+11*j+i], exp_bit(b[j], i));
                    n_fail++;
                end
            end
            $display("frame byte=%02h sent in order", b[j]);
        end
        wait_idle("queue");
    endtask

    task automatic test_random();
        int base = cap_q.size();
        logic [7:0] exp_q[$];
        for (int j = 0; j < 5; j++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            send(d);
        end
        wait_caps(base + 55, "random");
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if (cap_q[base+11*j+i] !== exp_bit(exp_q[j], i)) begin
                    $display("FAIL random_byte%0d_bit%0d: got %b required %b", j, i, cap_q[base+11*j+i], exp_bit(exp_q[j], i));
                    n_fail++;
                end
            end
            $display("frame byte=%02h sent", exp_q[j]);
        end
        wait_idle("random");
    endtask

    task automatic test_reset_mid_frame();
        int base = cap_q.size();
        int base2;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255)) & 8'hDF;
        send(d);
        wait_caps(base + 7, "midrst_pre");
        @(posedge clk);
        #3;
        n_checks++;
        if (ps2_clk_oe !== 1'b1 || ps2_data_oe !== 1'b1) begin
            $display("FAIL midrst_pre_drive: clk_oe=%b data_oe=%b required 1 1", ps2_clk_oe, ps2_data_oe);
            n_fail++;
        end
        reset_n = 1'b0;
        #1;
        n_checks += 4;
        if (ps2_clk_oe !== 1'b0)     begin $display("FAIL midrst_clk_oe: got %b required 0", ps2_clk_oe); n_fail++; end
        if (ps2_data_oe !== 1'b0)    begin $display("FAIL midrst_data_oe: got %b required 0", ps2_data_oe); n_fail++; end
        if (busy !== 1'b0)           begin $display("FAIL midrst_busy: got %b required 0", busy); n_fail++; end
        if (tx_if.tx_ready !== 1'b1) begin $display("FAIL midrst_ready: got %b required 1", tx_if.tx_ready); n_fail++; end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        base2 = cap_q.size();
        repeat (150) @(negedge clk);
        n_checks += 2;
        if (cap_q.size() != base2) begin $display("FAIL midrst_no_frame: got %0d bits required 0", cap_q.size() - base2); n_fail++; end
        if (busy !== 1'b0)         begin $display("FAIL midrst_idle: busy=%b required 0", busy); n_fail++; end
        $display("frame byte=%02h cut by reset at bit 6", d);
    endtask

    initial begin
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_inhibit();
        test_stop_inhibit();
        test_queueing();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
